// File: rtl/axi_rd_pkg.sv
// Shared types for the two-master AXI3 read-channel arbiter.
// Payload structs are sized from the package widths; the arbiter parameters must match them.
package axi_rd_pkg;

    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_LEN_W  = 4;

    // Master-index tag prepended to ARID on the slave side.
    localparam int unsigned MID_W     = 4;
    localparam int unsigned AXI_IDS_W = AXI_ID_W + MID_W;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } ar_t;

    typedef struct packed {
        logic [AXI_IDS_W-1:0]  id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } ars_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } r_t;

    typedef struct packed {
        logic [AXI_IDS_W-1:0]  id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } rs_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. On a contested grant the priority moves to the loser;
// uncontested grants leave the priority untouched.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_idx,
    output logic       any
);

    logic prio_q, prio_d;

    always_comb begin
        any     = |req;
        gnt_idx = (req == 2'b11) ? prio_q : req[1];
        prio_d  = prio_q;
        if (advance && (req == 2'b11)) begin
            prio_d = ~gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master to one-slave AXI3 read arbiter: one burst in flight, grant held from the
// AR handshake to the RLAST handshake, R beats routed back to the owner by the held grant.
module axi_rd_arbiter
    import axi_rd_pkg::*;
#(
    parameter int unsigned ID_W   = AXI_ID_W,
    parameter int unsigned ADDR_W = AXI_ADDR_W,
    parameter int unsigned DATA_W = AXI_DATA_W,
    parameter int unsigned LEN_W  = AXI_LEN_W
) (
    input  logic           clk,
    input  logic           rst,
    input  ar_t  [1:0]     ar_m,
    input  logic [1:0]     arvalid_m,
    output logic [1:0]     arready_m,
    output r_t   [1:0]     r_m,
    output logic [1:0]     rvalid_m,
    input  logic [1:0]     rready_m,
    output ars_t           ar_s,
    output logic           arvalid_s,
    input  logic           arready_s,
    input  rs_t            r_s,
    input  logic           rvalid_s,
    output logic           rready_s,
    output logic           err_len
);

    localparam int unsigned CNT_W = LEN_W + 1;

    state_t             state_q, state_d;
    logic               gnt_q, gnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               err_len_q, err_len_d;

    logic               arb_gnt, arb_any, arb_advance;
    ar_t                ar_sel;
    logic [ADDR_W-1:0]  araddr_sel;
    logic [DATA_W-1:0]  rdata_sel;
    r_t                 r_route;
    logic               r_hs, tag_bad, len_bad;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     (arvalid_m),
        .advance (arb_advance),
        .gnt_idx (arb_gnt),
        .any     (arb_any)
    );

    assign ar_sel     = ar_m[gnt_q];
    assign araddr_sel = ar_sel.addr;
    assign rdata_sel  = r_s.data;

    assign r_hs    = (state_q == DATA) && rvalid_s && rready_m[gnt_q];
    assign tag_bad = r_s.id[ID_W +: MID_W] != MID_W'(gnt_q);
    // A short burst ends early on RLAST; a long one keeps going past the latched length.
    assign len_bad = r_s.last ? (beat_cnt_q != CNT_W'(len_q))
                              : (beat_cnt_q == CNT_W'(len_q));

    always_comb begin
        r_route.id   = r_s.id[ID_W-1:0];
        r_route.data = rdata_sel;
        r_route.resp = r_s.resp;
        r_route.last = r_s.last;
    end

    always_comb begin
        arready_m = '0;
        rvalid_m  = '0;
        r_m       = '0;
        ar_s      = '0;
        arvalid_s = 1'b0;
        rready_s  = 1'b0;
        case (state_q)
            ADDR: begin
                arvalid_s        = 1'b1;
                ar_s.id          = {MID_W'(gnt_q), ar_sel.id};
                ar_s.addr        = araddr_sel;
                ar_s.len         = ar_sel.len;
                ar_s.size        = ar_sel.size;
                ar_s.burst       = ar_sel.burst;
                arready_m[gnt_q] = arready_s;
            end
            DATA: begin
                rvalid_m[gnt_q] = rvalid_s;
                rready_s        = rready_m[gnt_q];
                r_m[gnt_q]      = r_route;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        err_len_d   = err_len_q;
        arb_advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    arb_advance = 1'b1;
                    gnt_d       = arb_gnt;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (arready_s) begin
                    len_d      = ar_sel.len;
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (len_bad || tag_bad) begin
                        err_len_d = 1'b1;
                    end
                    if (r_s.last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            err_len_q  <= err_len_d;
        end
    end

    assign err_len = err_len_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter: the bench plays both masters and the slave, and
// predicts grants, routing and the length-error flag from a transaction-level model.
module tb_axi_rd_arbiter;
    import axi_rd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    ar_t  [1:0]  ar_m      = '0;
    logic [1:0]  arvalid_m = '0;
    logic [1:0]  arready_m;
    r_t   [1:0]  r_m;
    logic [1:0]  rvalid_m;
    logic [1:0]  rready_m  = '0;
    ars_t        ar_s;
    logic        arvalid_s;
    logic        arready_s = 1'b0;
    rs_t         r_s       = '0;
    logic        rvalid_s  = 1'b0;
    logic        rready_s;
    logic        err_len;

    always #5 clk = ~clk;

    axi_rd_arbiter u_dut (
        .clk       (clk),
        .rst       (rst),
        .ar_m      (ar_m),
        .arvalid_m (arvalid_m),
        .arready_m (arready_m),
        .r_m       (r_m),
        .rvalid_m  (rvalid_m),
        .rready_m  (rready_m),
        .ar_s      (ar_s),
        .arvalid_s (arvalid_s),
        .arready_s (arready_s),
        .r_s       (r_s),
        .rvalid_s  (rvalid_s),
        .rready_s  (rready_s),
        .err_len   (err_len)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: priority owner, sticky length error, masters with an outstanding request.
    logic       mdl_prio = 1'b0;
    logic       mdl_err  = 1'b0;
    logic [1:0] pend     = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    function automatic ar_t rand_ar();
        ar_t a;
        a.id    = 4'($urandom);
        a.addr  = $urandom;
        a.len   = 4'($urandom);
        a.size  = 3'($urandom_range(0, 2));
        a.burst = 2'($urandom_range(0, 2));
        return a;
    endfunction

    function automatic ars_t widen(input ar_t a, input logic m);
        ars_t w;
        w.id    = {(m ? 4'd1 : 4'd0), a.id};
        w.addr  = a.addr;
        w.len   = a.len;
        w.size  = a.size;
        w.burst = a.burst;
        return w;
    endfunction

    function automatic r_t strip(input rs_t r);
        r_t s;
        s.id   = r.id[3:0];
        s.data = r.data;
        s.resp = r.resp;
        s.last = r.last;
        return s;
    endfunction

    // One arbitration round: add requests, check the grant and AR forwarding, then play a
    // read burst as the slave. ar_wait < 0 picks a random AR stall; rst_beat >= 0 resets
    // the DUT when that beat index is about to be driven.
    task automatic do_round(input logic [1:0] new_req, input bit use_fix, input ar_t fix_ar,
                            input int extra_beats, input bit bad_tag, input int ar_wait,
                            input int rst_beat);
        logic w;
        int   nwait;
        int   nb;
        int   idx;
        int   cyc;
        bit   was_reset;
        logic [3:0] tag;

        to_drive();
        for (int m = 0; m < 2; m++) begin
            if (new_req[m] && !pend[m]) begin
                ar_m[m] = use_fix ? fix_ar : rand_ar();
                pend[m] = 1'b1;
            end
        end
        arvalid_m = pend;
        arready_s = 1'b0;
        rvalid_s  = 1'($urandom);
        rready_m  = 2'b11;
        r_s       = '0;
        to_sample();
        check_eq("idle_arvalid_s", 64'(arvalid_s), 64'(0));
        check_eq("idle_arready_m", 64'(arready_m), 64'(0));
        check_eq("idle_ar_s", 64'(ar_s), 64'(0));
        check_eq("idle_rready_s", 64'(rready_s), 64'(0));
        check_eq("idle_rvalid_m", 64'(rvalid_m), 64'(0));
        check_eq("idle_err_len", 64'(err_len), 64'(mdl_err));
        if (pend == 2'b00) return;

        if (pend == 2'b11) begin
            w        = mdl_prio;
            mdl_prio = ~w;
        end else begin
            w = pend[1];
        end

        nwait = (ar_wait < 0) ? $urandom_range(0, 5) : ar_wait;
        for (int c = 0; c <= nwait; c++) begin
            to_drive();
            arready_s = (c == nwait);
            rvalid_s  = 1'($urandom);
            to_sample();
            check_eq("ar_arvalid_s", 64'(arvalid_s), 64'(1));
            check_eq("ar_payload", 64'(ar_s), 64'(widen(ar_m[w], w)));
            check_eq("ar_arready_m", 64'(arready_m), arready_s ? 64'(2'b01 << w) : 64'(0));
            check_eq("ar_rready_s", 64'(rready_s), 64'(0));
        end

        nb        = int'(ar_m[w].len) + 1 + extra_beats;
        idx       = 0;
        cyc       = 0;
        was_reset = 1'b0;
        while (idx < nb && cyc < 300) begin
            to_drive();
            if (cyc == 0) begin
                arready_s = 1'b0;
                pend[w]   = 1'b0;
                arvalid_m = pend;
            end
            if (idx == rst_beat) begin
                rvalid_s = 1'b1;
                rready_m = 2'b11;
                rst      = 1'b0;
                #1;
                check_eq("rst_arvalid_s", 64'(arvalid_s), 64'(0));
                check_eq("rst_rready_s", 64'(rready_s), 64'(0));
                check_eq("rst_rvalid_m", 64'(rvalid_m), 64'(0));
                check_eq("rst_arready_m", 64'(arready_m), 64'(0));
                check_eq("rst_err_len", 64'(err_len), 64'(0));
                pend      = '0;
                arvalid_m = '0;
                rvalid_s  = 1'b0;
                mdl_prio  = 1'b0;
                mdl_err   = 1'b0;
                to_drive();
                rst       = 1'b1;
                was_reset = 1'b1;
                break;
            end
            rvalid_s   = ($urandom_range(0, 9) < 7);
            rready_m   = 2'($urandom);
            tag        = (bad_tag && idx == 0) ? {3'b0, ~w} : {3'b0, w};
            r_s.id     = {tag, ar_m[w].id};
            r_s.data   = $urandom;
            r_s.resp   = 2'($urandom);
            r_s.last   = (idx == nb - 1);
            to_sample();
            check_eq("r_err_len", 64'(err_len), 64'(mdl_err));
            check_eq("r_rvalid_m", 64'(rvalid_m), rvalid_s ? 64'(2'b01 << w) : 64'(0));
            check_eq("r_rready_s", 64'(rready_s), 64'(rready_m[w]));
            check_eq("r_owner_data", 64'(r_m[w]), 64'(strip(r_s)));
            check_eq("r_other_data", 64'(r_m[~w]), 64'(0));
            check_eq("r_arready_m", 64'(arready_m), 64'(0));
            if (rvalid_s && rready_m[w]) begin
                if (bad_tag && idx == 0) mdl_err = 1'b1;
                if (r_s.last && idx != int'(ar_m[w].len)) mdl_err = 1'b1;
                if (!r_s.last && idx == int'(ar_m[w].len)) mdl_err = 1'b1;
                idx++;
            end
            cyc++;
        end
        if (!was_reset) begin
            check_eq("burst_complete", 64'(idx), 64'(nb));
        end
    endtask

    initial begin
        ar_t fix;
        fix = '0;

        // Reset state with noisy inputs.
        rvalid_s = 1'b1;
        rready_m = 2'b11;
        #2;
        check_eq("reset_arready_m", 64'(arready_m), 64'(0));
        check_eq("reset_rvalid_m", 64'(rvalid_m), 64'(0));
        check_eq("reset_arvalid_s", 64'(arvalid_s), 64'(0));
        check_eq("reset_rready_s", 64'(rready_s), 64'(0));
        check_eq("reset_ar_s", 64'(ar_s), 64'(0));
        check_eq("reset_r_m0", 64'(r_m[0]), 64'(0));
        check_eq("reset_r_m1", 64'(r_m[1]), 64'(0));
        check_eq("reset_err_len", 64'(err_len), 64'(0));
        to_drive();
        rvalid_s = 1'b0;
        rready_m = 2'b00;
        rst      = 1'b1;

        // M0 alone, ARLEN=3, ARID=2, with a 5-cycle AR stall.
        fix.id    = 4'd2;
        fix.addr  = 32'h0001_0000;
        fix.len   = 4'd3;
        fix.size  = 3'd2;
        fix.burst = 2'd1;
        do_round(2'b01, 1'b1, fix, 0, 1'b0, 5, -1);

        // Both requesting: grants must alternate starting with M0.
        for (int i = 0; i < 6; i++) begin
            do_round(2'b11, 1'b0, fix, 0, 1'b0, -1, -1);
        end

        // Random mix of requesters and burst lengths.
        for (int i = 0; i < 40; i++) begin
            do_round(2'($urandom), 1'b0, fix, 0, 1'b0, -1, -1);
        end
        while (pend != 2'b00) begin
            do_round(2'b00, 1'b0, fix, 0, 1'b0, -1, -1);
        end

        // ARLEN=1 but the slave sends three beats.
        fix.len = 4'd1;
        do_round(2'b01, 1'b1, fix, 1, 1'b0, 0, -1);
        do_round(2'b00, 1'b0, fix, 0, 1'b0, -1, -1);

        // Leave priority with M1 (if needed), then reset during beat 2 of a 4-beat burst.
        if (mdl_prio) begin
            do_round(2'b11, 1'b0, fix, 0, 1'b0, -1, -1);
        end
        fix.len = 4'd3;
        do_round(2'b11, 1'b1, fix, 0, 1'b0, 0, 1);

        // After reset a contested grant goes to M0 again.
        do_round(2'b11, 1'b0, fix, 0, 1'b0, -1, -1);

        // Wrong master tag on the first beat of M1's burst.
        do_round(2'b00, 1'b0, fix, 0, 1'b1, -1, -1);
        do_round(2'b00, 1'b0, fix, 0, 1'b0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
